// File: rtl/aoi_exp_pkg.sv
// Shared types and constants for the AOI expander monitor.
// Holds the monitor FSM state encoding, the result counter width and a
// saturating increment helper used by the live edge counter.
package aoi_exp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = 255;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                  input logic            inc);
        if (inc && (value != CNT_W'(CNT_MAX))) begin
            return value + 1'b1;
        end
        return value;
    endfunction

endpackage

// File: rtl/aoi_exp_sync.sv
// Parameterized-width two-flop synchronizer with a per-bit reset value.
// Each bit is treated independently; no multi-bit coherency is implied.
module aoi_exp_sync
    import aoi_exp_pkg::*;
#(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two-stage capture of the asynchronous inputs into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aoi_exp_monitor.sv
// Falling-edge window counter and expander-pair checker for an AOI gate.
// Counts synchronized falling edges of Y over WINDOW-cycle windows and
// reports each result through a VALID/READY handshake, flagging dropped
// results on OVR.  The expander-pair check that drives FAULT is only built
// when the macro AOI_EXP_FAULT_CHECK_EN is defined; otherwise FAULT is 0.
module aoi_exp_monitor
    import aoi_exp_pkg::*;
#(
    parameter int WINDOW    = 16,
    parameter int FAULT_LIM = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Y,
    input  logic             X,
    input  logic             XBAR,
    input  logic             EN,
    input  logic             READY,
    output logic             VALID,
    output logic [CNT_W-1:0] CNT,
    output logic             EDGE,
    output logic             OVR,
    output logic             FAULT
);

    localparam int         TMR_W    = 16;
    localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WINDOW - 1);

    logic [2:0]       sync_q;
    logic             y_s;
    logic             x_s;
    logic             xbar_s;
    logic             y_d;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] live_cnt;
    logic [CNT_W-1:0] live_nxt;
    logic [CNT_W-1:0] live_inc;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             valid_nxt;
    logic             ovr_nxt;
    logic             win_end;

    aoi_exp_sync #(
        .W       (3),
        .RST_VAL (3'b110)
    ) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   ({Y, X, XBAR}),
        .q   (sync_q)
    );

    assign y_s    = sync_q[2];
    assign x_s    = sync_q[1];
    assign xbar_s = sync_q[0];

    // Delay synchronized Y one cycle and register a pulse on each 1->0 step
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            y_d  <= 1'b1;
            EDGE <= 1'b0;
        end else begin
            y_d  <= y_s;
            EDGE <= y_d & ~y_s;
        end
    end

    // Next-state, window timing, result load and overrun decisions
    always_comb begin
        state_nxt = state;
        live_nxt  = live_cnt;
        timer_nxt = timer;
        cnt_nxt   = CNT;
        valid_nxt = VALID;
        ovr_nxt   = OVR;
        live_inc  = sat_inc(live_cnt, EDGE);
        win_end   = (timer == WIN_LAST);

        if (!EN) begin
            state_nxt = IDLE;
            live_nxt  = '0;
            timer_nxt = '0;
            valid_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = COUNT;
                    live_nxt  = '0;
                    timer_nxt = '0;
                end
                COUNT: begin
                    if (win_end) begin
                        cnt_nxt   = live_inc;
                        valid_nxt = 1'b1;
                        live_nxt  = '0;
                        timer_nxt = '0;
                        state_nxt = REPORT;
                    end else begin
                        live_nxt  = live_inc;
                        timer_nxt = timer + 1'b1;
                    end
                end
                REPORT: begin
                    if (win_end) begin
                        live_nxt  = '0;
                        timer_nxt = '0;
                        if (VALID && !READY) begin
                            ovr_nxt = 1'b1;
                        end else begin
                            cnt_nxt   = live_inc;
                            valid_nxt = 1'b1;
                        end
                    end else begin
                        live_nxt  = live_inc;
                        timer_nxt = timer + 1'b1;
                        if (VALID && READY) begin
                            valid_nxt = 1'b0;
                            state_nxt = COUNT;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, counters and reported result registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            live_cnt <= '0;
            timer    <= '0;
            CNT      <= '0;
            VALID    <= 1'b0;
            OVR      <= 1'b0;
        end else begin
            state    <= state_nxt;
            live_cnt <= live_nxt;
            timer    <= timer_nxt;
            CNT      <= cnt_nxt;
            VALID    <= valid_nxt;
            OVR      <= ovr_nxt;
        end
    end

`ifdef AOI_EXP_FAULT_CHECK_EN
    localparam logic [3:0] RUN_LAST = 4'(FAULT_LIM - 1);

    logic [3:0] bad_run;
    logic       pair_bad;

    assign pair_bad = (x_s == xbar_s);

    // Track consecutive invalid expander cycles and latch FAULT at the limit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bad_run <= '0;
            FAULT   <= 1'b0;
        end else if (!pair_bad) begin
            bad_run <= '0;
        end else begin
            if (bad_run != 4'hF) begin
                bad_run <= bad_run + 4'd1;
            end
            if (bad_run == RUN_LAST) begin
                FAULT <= 1'b1;
            end
        end
    end
`else
    logic unused_expander;

    assign unused_expander = x_s ^ xbar_s;
    assign FAULT           = 1'b0;
`endif

endmodule

// File: doc/aoi_exp_monitor.md
AOI_EXP_MONITOR -- requirements
Module: aoi_exp_monitor

Interface
REQ-001 SHALL have parameter WINDOW, default 16, meaning cycles per count window (range 2..65535).
REQ-002 SHALL have parameter FAULT_LIM, default 3, meaning consecutive bad expander-pair cycles before FAULT is raised (range 1..15).
REQ-003 SHALL have ports, one clock and async active-high reset:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- Y  in  1  AOI output being monitored (asynchronous to CLK).
- X  in  1  expander X line (asynchronous).
- XBAR  in  1  expander XBAR line (asynchronous).
- EN  in  1  monitor enable.
- READY  in  1  consumer accepts CNT.
- VALID  out  1  CNT holds a completed window result.
- CNT  out  8  falling edges of Y counted in the last completed window.
- EDGE  out  1  one-cycle pulse per detected falling edge of Y.
- OVR  out  1  sticky flag: a window result was dropped.
- FAULT  out  1  sticky flag: expander pair invalid.

Function
REQ-004 SHALL pass Y, X and XBAR through a 2-flop synchronizer before any use.
REQ-005 SHALL register EDGE high for exactly one cycle when synchronized Y goes from 1 to 0.
- Latency is the third rising CLK edge after Y falls.
REQ-006 SHALL implement FSM states IDLE, COUNT and REPORT.
- IDLE->COUNT when EN=1.
- Any state->IDLE when EN=0.
REQ-007 On entering COUNT, SHALL clear the live edge counter and the window timer.
REQ-008 Live counter width rules:
- 8 bits.
- Increments on each EDGE.
- Saturates at 255, with no wrap-around.
REQ-009 Window end: when the timer reaches WINDOW-1, the block SHALL:
- load CNT with the live count, including an edge detected in that same cycle;
- assert VALID;
- clear the live counter and timer;
- enter REPORT.
REQ-010 In REPORT, counting and windowing SHALL continue exactly as in COUNT.
- VALID and CNT SHALL stay stable until VALID&READY is sampled high.
- The block then returns to COUNT with VALID=0 the next cycle.
REQ-011 If a window ends in REPORT while VALID=1 and READY=0, the block SHALL:
- keep the old CNT;
- drop the new result;
- set OVR.
If READY=1 in that same cycle, the new result SHALL load and VALID SHALL stay high; no overrun.
REQ-012 EN falling SHALL, on the next edge:
- clear VALID, the live counter and the timer;
- leave CNT holding its last value;
- leave OVR and FAULT unchanged.
REQ-013 The expander pair is invalid when synchronized X equals synchronized XBAR.
- FAULT SHALL set when the pair is invalid for FAULT_LIM consecutive cycles.
- The run counter SHALL clear on any valid cycle.
- The check SHALL run regardless of EN.

Reset
REQ-014 RST high SHALL asynchronously force:
- FSM=IDLE;
- VALID=0, CNT=0, EDGE=0, OVR=0, FAULT=0;
- synchronizers to 1,1,0 (Y, X, XBAR);
- all counters to 0.
REQ-015 Release of RST SHALL need no EN sequencing; a spurious EDGE after reset is forbidden.

Configuration
REQ-016 Macro AOI_EXP_FAULT_CHECK_EN controls the expander-pair check:
- Defined: the REQ-013 logic is present.
- Undefined: FAULT is tied to 0, the run counter is absent, and X/XBAR are unused.

Structure
REQ-017 Package aoi_exp_pkg SHALL hold:
- the FSM state enum (IDLE, COUNT, REPORT);
- constant CNT_W=8;
- constant CNT_MAX=255.
REQ-018 Sub-module aoi_exp_sync SHALL be a parameterized-width 2-flop synchronizer with a reset value vector, instantiated once for the 3 inputs.

Verification
REQ-019 Basic window count:
- Stimulus: EN=1, READY=1, WINDOW=16, 5 Y falling pulses in one window.
- Response: VALID one cycle with CNT=5; 5 EDGE pulses, each 3 edges after its Y fall.
REQ-020 Saturation:
- Stimulus: WINDOW=600, Y toggling every cycle.
- Response: CNT=255, no wrap.
REQ-021 Backpressure and overrun:
- Stimulus: READY=0 across two window ends, 3 then 7 edges.
- Response: CNT stays 3, OVR=1; after READY=1, VALID drops next cycle.
REQ-022 Simultaneous window end and READY:
- Stimulus: window end coincides with READY=1 while VALID=1, holding result 4, with 9 new edges.
- Response: CNT=9, VALID stays 1, OVR=0.
REQ-023 Expander fault:
- Stimulus: X=XBAR=1 for 2 cycles, then valid, then X=XBAR=0 for 3 cycles (FAULT_LIM=3).
- Response: FAULT=1 only after the third bad cycle; with the macro undefined, FAULT stays 0.
REQ-024 Reset mid-window:
- Stimulus: RST pulse mid-window with 4 edges counted and VALID=1.
- Response: all outputs 0 immediately, no EDGE after release, next window counts from 0.
